// File: rtl/onchip_ram_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share one single-port on-chip RAM (1-cycle read latency).
// Optional build macro ONCHIP_RAM_ARB_RANGE_CHECK_EN blocks accesses at or above DEPTH and adds a sticky range_err output.
module onchip_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2560,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
  ,
  output logic              range_err
`endif
);

  logic req0, req1, grant0, grant1, granted;
  logic sel_write, issue_read, oor;
  logic last_grant, rd_pend, rd_owner;
  logic [DATA_W-1:0] rdata;

  // NOTE: every signal written in always_comb gets a value on every path, so no latches are inferred.
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    // last_grant names the previous winner; the other master wins a contest.
    grant0  = reset_n & req0 & (~req1 | last_grant);
    grant1  = reset_n & req1 & (~req0 | ~last_grant);
    granted = grant0 | grant1;

    ram_address    = grant1 ? m1_address    : m0_address;
    ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
    sel_write      = grant1 ? m1_write      : m0_write;

`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
    oor = ({1'b0, ram_address} >= (ADDR_W + 1)'(DEPTH));
`else
    oor = 1'b0;
`endif

    ram_chipselect = granted & ~oor;
    ram_write      = granted & sel_write & ~oor;
    ram_clken      = reset_n;
    issue_read     = granted & ~sel_write;

    m0_waitrequest = req0 & ~grant0;
    m1_waitrequest = req1 & ~grant1;
  end

`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
  function automatic logic [DATA_W-1:0] err_word();
    logic [31:0] pat;
    pat = 32'hDEAD_BEEF;
    for (int i = 0; i < DATA_W; i++) err_word[i] = pat[i % 32];
  endfunction

  localparam logic [DATA_W-1:0] ERR_WORD = err_word();

  logic rd_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_err    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      rd_err <= issue_read & oor;
      if (granted && oor) range_err <= 1'b1;
    end
  end

  assign rdata = rd_err ? ERR_WORD : ram_readdata;
`else
  assign rdata = ram_readdata;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (granted) last_grant <= grant1;
      rd_pend <= issue_read;
      if (issue_read) rd_owner <= grant1;
    end
  end

  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Randomised self-checking bench for onchip_ram_arbiter: a behavioural RAM plus a transaction-level reference model.
// Building with ONCHIP_RAM_ARB_RANGE_CHECK_EN also checks range_err and the out-of-range error data.
module tb_onchip_ram_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2560;
  localparam int BE_W   = 4;
`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              m_rd [2];
  logic              m_wr [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [BE_W-1:0]   m_be [2];
  logic [DATA_W-1:0] m_wd [2];

  logic [DATA_W-1:0] m0_readdata, m1_readdata, ram_writedata;
  logic [DATA_W-1:0] ram_readdata;
  logic m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic ram_chipselect, ram_write, ram_clken;
`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
  logic range_err;
`endif

  onchip_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BE_W(BE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m_addr[0]), .m0_byteenable(m_be[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
    .m0_writedata(m_wd[0]), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m_addr[1]), .m1_byteenable(m_be[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
    .m1_writedata(m_wd[1]), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
    ,
    .range_err(range_err)
`endif
  );

  // Behavioural RAM, deep enough for the full address space so nothing aliases.
  logic [DATA_W-1:0] ram_mem [4096];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [4096];
  int                ref_last;
  bit                ref_pend;
  int                ref_owner;
  logic [DATA_W-1:0] ref_data;
  bit                ref_rerr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic set_m(input int i, input bit rd, input bit wr, input int addr,
                       input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    m_rd[i] = rd; m_wr[i] = wr; m_addr[i] = ADDR_W'(addr); m_be[i] = be; m_wd[i] = wd;
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 32'hC3C3_0000 ^ (i * 32'h0001_0203);
  endfunction

  // One clock cycle: predict, sample mid-cycle, then advance the model at the edge.
  task automatic step();
    bit r0, r1, oor, wr;
    int win, a;
    r0 = m_rd[0] | m_wr[0];
    r1 = m_rd[1] | m_wr[1];
    if (!reset_n)       win = -1;
    else if (r0 && r1)  win = (ref_last == 1) ? 0 : 1;
    else if (r0)        win = 0;
    else if (r1)        win = 1;
    else                win = -1;
    a   = (win == 1) ? int'(m_addr[1]) : int'(m_addr[0]);
    wr  = (win >= 0) && ((win == 1) ? m_wr[1] : m_wr[0]);
    oor = (win >= 0) && RC && (a >= DEPTH);

    @(negedge clk);
    check("m0_waitrequest", m0_waitrequest, r0 && win != 0);
    check("m1_waitrequest", m1_waitrequest, r1 && win != 1);
    check("m0_readdatavalid", m0_readdatavalid, ref_pend && ref_owner == 0);
    check("m1_readdatavalid", m1_readdatavalid, ref_pend && ref_owner == 1);
    if (ref_pend) check("owner_readdata", (ref_owner == 1) ? m1_readdata : m0_readdata, ref_data);
    check("ram_chipselect", ram_chipselect, (win >= 0) && !oor);
    check("ram_write", ram_write, wr && !oor);
    check("ram_clken", ram_clken, reset_n);
    if (reset_n) begin
      check("ram_address", ram_address, a);
      check("ram_byteenable", ram_byteenable, (win == 1) ? m_be[1] : m_be[0]);
      check("ram_writedata", ram_writedata, (win == 1) ? m_wd[1] : m_wd[0]);
    end
`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
    check("range_err", range_err, ref_rerr);
`endif

    @(posedge clk);
    if (!reset_n) begin
      ref_pend = 0; ref_last = 1; ref_rerr = 0;
    end else begin
      ref_pend = 0;
      if (win >= 0) begin
        ref_last = win;
        if (oor) ref_rerr = 1;
        if (wr) begin
          if (!oor)
            for (int b = 0; b < BE_W; b++)
              if (m_be[win][b]) ref_mem[a][8*b +: 8] = m_wd[win][8*b +: 8];
        end else begin
          ref_pend  = 1;
          ref_owner = win;
          ref_data  = oor ? 32'hDEAD_BEEF : ref_mem[a];
        end
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    ram_readdata = '0;
    ref_last = 1; ref_pend = 0; ref_owner = 0; ref_data = '0; ref_rerr = 0;
    idle_all();

    // Held in reset: a requester stalls, an idle master does not.
    set_m(1, 1, 0, 3, 4'hF, '0);
    step();
    step();
    reset_n = 1'b1;

    // Contention right after reset: m0 first, then m1, returns in order.
    set_m(0, 1, 0, 8, 4'hF, '0);
    set_m(1, 1, 0, 9, 4'hF, '0);
    step();
    set_m(0, 0, 0, 0, '0, '0);
    step();
    idle_all();
    step();

    // Single master write then read back.
    set_m(0, 0, 1, 'h010, 4'hF, 32'h1234_5678);
    step();
    set_m(0, 1, 0, 'h010, 4'hF, '0);
    step();
    idle_all();
    step();

    // Sustained contention: grants alternate every cycle.
    for (int c = 0; c < 6; c++) begin
      set_m(0, 1, 0, 'h020 + c, 4'hF, '0);
      set_m(1, 1, 0, 'h040 + c, 4'hF, '0);
      step();
    end
    idle_all();
    step();

    // Byte-enable merge at 0x7FF.
    set_m(0, 0, 1, 'h7FF, 4'hF, 32'hAABB_CCDD);
    step();
    set_m(0, 0, 1, 'h7FF, 4'b0001, 32'h0000_00EE);
    step();
    set_m(0, 1, 0, 'h7FF, 4'hF, '0);
    step();
    idle_all();
    step();

    // Reset asserted between a granted m1 read and its return edge.
    set_m(1, 1, 0, 'h005, 4'hF, '0);
    @(negedge clk);
    check("midrst_m1_grant", m1_waitrequest, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_m1_stall", m1_waitrequest, 1'b1);
    check("midrst_clken", ram_clken, 1'b0);
    ref_pend = 0; ref_last = 1; ref_rerr = 0;
    @(posedge clk);
    #1;
    idle_all();
    step();
    reset_n = 1'b1;
    set_m(0, 1, 0, 'h011, 4'hF, '0);
    set_m(1, 1, 0, 'h012, 4'hF, '0);
    step();
    idle_all();
    step();
    step();

`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
    // Out-of-range read returns the error word and latches range_err.
    set_m(0, 1, 0, 'hA00, 4'hF, '0);
    step();
    idle_all();
    step();
    step();
`endif

    // Randomised traffic, mostly on a small window so writes and reads collide.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        int kind, addr;
        kind = $urandom_range(0, 9);
        addr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 15);
        set_m(i, kind inside {[2:5], 9}, kind inside {[6:9]}, addr,
              BE_W'($urandom), $urandom);
      end
      step();
    end
    idle_all();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
Two-master Avalon-MM arbiter sharing one single-port on-chip RAM: 32-bit words, 2560 words deep, 12-bit word address, byte enables, 1-cycle read latency.
- Master 0 is the Nios II data master; master 1 is a DMA/debug requester.
- Sits between both masters and the RAM slave.
- Serialises accesses with round-robin arbitration.
- Returns read data to the owning master.

Parameters:
ADDR_W, 12, word address width
DATA_W, 32, data width (multiple of 8)
DEPTH, 2560, number of valid RAM words
BE_W, DATA_W/8, byte-enable width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  BE_W  master 0 byte enables
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_readdata  out  DATA_W  master 0 read data
m0_waitrequest  out  1  master 0 stall
m0_readdatavalid  out  1  master 0 read data valid
m1_*  same set as m0_*, for master 1
ram_address  out  ADDR_W  to RAM address
ram_byteenable  out  BE_W  to RAM byteenable
ram_chipselect  out  1  to RAM chipselect
ram_write  out  1  to RAM write
ram_writedata  out  DATA_W  to RAM writedata
ram_clken  out  1  to RAM clken
ram_readdata  in  DATA_W  from RAM readdata (valid 1 cycle after the address is sampled)

Behaviour:
- A request from master i is reqi = mi_read | mi_write.
  - If read and write are both asserted, the access is treated as a write; no readdatavalid is produced.
- Arbitration is combinational each cycle.
  - Only one master requesting: that master wins.
  - Both requesting: the master not in last_grant wins.
  - last_grant (1 bit) updates at each clock edge on which a grant occurs.
  - Reset value of last_grant = 1, so master 0 wins the first contest.
- Winner:
  - mi_waitrequest = 0.
  - RAM ports are muxed from the winner.
  - ram_chipselect = 1.
  - ram_write = winner write.
- Loser, or any requester while reset_n = 0: waitrequest = 1.
- Idle master with no request: waitrequest = 0 (Avalon idle convention).
- No grant: ram_chipselect = 0, ram_write = 0; address, byteenable and writedata hold the master-0 mux values.
- ram_clken = 1 whenever reset_n = 1; 0 during reset.
- Read return pipeline:
  - On a granted read in cycle N, the registers rd_pend = 1 and rd_owner = i are set.
  - In cycle N+1: mi_readdatavalid = 1 for the owner only, with mi_readdata = ram_readdata.
  - readdata of the non-owner is driven with ram_readdata but is not valid.
  - Back-to-back reads (same or alternating masters) sustain one read per cycle; returns arrive strictly in issue order.
- Writes complete in the grant cycle. No response is generated.
- Write-then-read to the same address in consecutive cycles: the read returns the new data (RAM write completes at edge N).
- Reset:
  - Asynchronous assertion clears rd_pend (a pending readdatavalid is dropped, never emitted) and sets last_grant = 1.
  - All readdatavalid outputs are 0 during reset and in the first cycle after deassertion.
- Width rules: addresses are passed through unmodified. Addresses >= DEPTH are forwarded as-is (aliasing is the RAM's behaviour) unless the optional feature is compiled in.

Optional Feature:
ONCHIP_RAM_ARB_RANGE_CHECK_EN
- Defined:
  - Any granted access with address >= DEPTH is accepted (waitrequest = 0) but ram_chipselect = 0.
  - Such writes are dropped.
  - Such reads return readdatavalid in N+1 with readdata = 32'hDEADBEEF (truncated/replicated to DATA_W).
  - Adds output range_err (1 bit): sticky, set on the first out-of-range access, cleared only by reset (reset value 0).
- Undefined: no range_err port; all addresses are forwarded.

Test Plan:
- Single master: m0 writes 0x12345678 to address 0x010 with byteenable 4'b1111, then reads 0x010 -> m0_waitrequest = 0 both cycles; m0_readdatavalid one cycle after the read; m0_readdata = 0x12345678.
- Contention after reset: m0 and m1 both read in the same cycle -> m0 granted first, m1 waitrequest = 1; m1 granted next cycle; readdatavalid arrives for m0 then m1 on consecutive cycles.
- Sustained contention of 6 cycles with both requesting -> grants alternate 0,1,0,1,0,1; neither master stalls for more than 1 cycle.
- Byte enable: write 0xAABBCCDD then 0x000000EE with byteenable 4'b0001 to address 0x7FF -> read returns 0xAABBCCEE.
- Reset mid-read: grant m1 read, assert reset_n = 0 before the next edge -> no m1_readdatavalid; after release, m0 wins the first contest.
- With ONCHIP_RAM_ARB_RANGE_CHECK_EN: m0 reads address 0xA00 (2560) -> ram_chipselect = 0, m0_readdata = 0xDEADBEEF, range_err goes 1 and stays 1.
